// File: rtl/frame_stream_monitor.sv
// Receive-side monitor for the rendered pixel stream: locks to frame starts, checks
// line/frame geometry and position tracking, and reports a per-frame checksum and count.
module frame_stream_monitor #(
    parameter int COLOR_BITS = 24,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    display_enable_i,
    input  logic [9:0]              hpos_i,
    input  logic [9:0]              vpos_i,
    input  logic [COLOR_BITS/3-1:0] red_i,
    input  logic [COLOR_BITS/3-1:0] green_i,
    input  logic [COLOR_BITS/3-1:0] blue_i,
    input  logic                    err_clear_i,
    output logic                    synced_o,
    output logic                    frame_done_o,
    output logic [31:0]             frame_checksum_o,
    output logic [15:0]             frame_count_o,
    output logic                    pos_err_o,
    output logic                    line_err_o,
    output logic                    frame_err_o
);

    typedef enum logic [1:0] {
        SYNC_WAIT,
        ACTIVE,
        HBLANK,
        FRAME_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] pix_cnt_q, pix_cnt_d;
    logic [9:0]  line_cnt_q, line_cnt_d;
    logic [31:0] csum_q, csum_d;
    logic        synced_q, synced_d;
    logic        frame_done_q, frame_done_d;
    logic [31:0] frame_checksum_q, frame_checksum_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic        pos_err_q, pos_err_d;
    logic        line_err_q, line_err_d;
    logic        frame_err_q, frame_err_d;

    logic [31:0] pix_word;
    logic        is_origin;
    logic        start_frame;
    logic        pos_set, line_set, frame_set;

    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    function automatic logic [31:0] csum_step(input logic [31:0] c, input logic [31:0] p);
        return {c[30:0], c[31]} ^ p;
    endfunction

    assign pix_word  = 32'({red_i, green_i, blue_i});
    assign is_origin = display_enable_i && (hpos_i == 10'd0) && (vpos_i == 10'd0);

    always_comb begin
        state_d          = state_q;
        pix_cnt_d        = pix_cnt_q;
        line_cnt_d       = line_cnt_q;
        csum_d           = csum_q;
        frame_done_d     = 1'b0;
        frame_checksum_d = frame_checksum_q;
        frame_count_d    = frame_count_q;
        start_frame      = 1'b0;
        pos_set          = 1'b0;
        line_set         = 1'b0;
        frame_set        = 1'b0;

        case (state_q)
            SYNC_WAIT: begin
                start_frame = is_origin;
            end
            ACTIVE: begin
                if (display_enable_i) begin
                    pos_set   = ({1'b0, hpos_i} != pix_cnt_q) || (vpos_i != line_cnt_q);
                    csum_d    = csum_step(csum_q, pix_word);
                    pix_cnt_d = sat_inc(pix_cnt_q);
                end else begin
                    line_set = (pix_cnt_q != 11'(H_ACTIVE));
                    if (line_cnt_q == 10'(V_ACTIVE - 1)) begin
                        frame_done_d     = 1'b1;
                        frame_checksum_d = csum_q;
                        frame_count_d    = frame_count_q + 16'd1;
                        state_d          = FRAME_WAIT;
                    end else begin
                        line_cnt_d = line_cnt_q + 10'd1;
                        pix_cnt_d  = 11'd0;
                        state_d    = HBLANK;
                    end
                end
            end
            HBLANK: begin
                if (is_origin) begin
                    // A (0,0) pixel mid-frame means the source restarted early.
                    frame_set   = 1'b1;
                    start_frame = 1'b1;
                end else if (display_enable_i) begin
                    pos_set   = (hpos_i != 10'd0) || (vpos_i != line_cnt_q);
                    csum_d    = csum_step(csum_q, pix_word);
                    pix_cnt_d = 11'd1;
                    state_d   = ACTIVE;
                end
            end
            FRAME_WAIT: begin
                if (is_origin) begin
                    start_frame = 1'b1;
                end else if (display_enable_i) begin
                    pos_set = 1'b1;
                end
            end
            default: state_d = SYNC_WAIT;
        endcase

        if (start_frame) begin
            csum_d     = pix_word;
            pix_cnt_d  = 11'd1;
            line_cnt_d = 10'd0;
            state_d    = ACTIVE;
        end

        // A new error in the same cycle as a clear keeps the flag set.
        pos_err_d   = pos_set   | (pos_err_q   & ~err_clear_i);
        line_err_d  = line_set  | (line_err_q  & ~err_clear_i);
        frame_err_d = frame_set | (frame_err_q & ~err_clear_i);
        synced_d    = (state_d != SYNC_WAIT);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q          <= SYNC_WAIT;
            pix_cnt_q        <= '0;
            line_cnt_q       <= '0;
            csum_q           <= '0;
            synced_q         <= 1'b0;
            frame_done_q     <= 1'b0;
            frame_checksum_q <= '0;
            frame_count_q    <= '0;
            pos_err_q        <= 1'b0;
            line_err_q       <= 1'b0;
            frame_err_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            pix_cnt_q        <= pix_cnt_d;
            line_cnt_q       <= line_cnt_d;
            csum_q           <= csum_d;
            synced_q         <= synced_d;
            frame_done_q     <= frame_done_d;
            frame_checksum_q <= frame_checksum_d;
            frame_count_q    <= frame_count_d;
            pos_err_q        <= pos_err_d;
            line_err_q       <= line_err_d;
            frame_err_q      <= frame_err_d;
        end
    end

    assign synced_o         = synced_q;
    assign frame_done_o     = frame_done_q;
    assign frame_checksum_o = frame_checksum_q;
    assign frame_count_o    = frame_count_q;
    assign pos_err_o        = pos_err_q;
    assign line_err_o       = line_err_q;
    assign frame_err_o      = frame_err_q;

endmodule

// File: tb/tb_frame_stream_monitor.sv
// Directed bench for frame_stream_monitor on a 4x3 frame with hand-computed checksums.
module tb_frame_stream_monitor;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int CB = 24;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        display_enable_i;
    logic [9:0]  hpos_i, vpos_i;
    logic [7:0]  red_i, green_i, blue_i;
    logic        err_clear_i;
    logic        synced_o, frame_done_o;
    logic [31:0] frame_checksum_o;
    logic [15:0] frame_count_o;
    logic        pos_err_o, line_err_o, frame_err_o;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int d0;

    always #5 clk = ~clk;

    frame_stream_monitor #(.COLOR_BITS(CB), .H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk_i(clk), .reset_i(reset_i), .display_enable_i(display_enable_i),
        .hpos_i(hpos_i), .vpos_i(vpos_i), .red_i(red_i), .green_i(green_i), .blue_i(blue_i),
        .err_clear_i(err_clear_i), .synced_o(synced_o), .frame_done_o(frame_done_o),
        .frame_checksum_o(frame_checksum_o), .frame_count_o(frame_count_o),
        .pos_err_o(pos_err_o), .line_err_o(line_err_o), .frame_err_o(frame_err_o)
    );

    always @(posedge clk) if (frame_done_o) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic px(input int h, input int v, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        display_enable_i = 1'b1;
        hpos_i = 10'(h);
        vpos_i = 10'(v);
        red_i = r; green_i = g; blue_i = b;
        step();
    endtask

    task automatic bl(input int n);
        display_enable_i = 1'b0;
        repeat (n) step();
    endtask

    task automatic send_line(input int v, input int n);
        for (int i = 0; i < n; i++) px(i, v, 8'h00, 8'h00, 8'h01);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_synced"}, 32'(synced_o), 32'd0);
        check({tag, "_done"},   32'(frame_done_o), 32'd0);
        check({tag, "_csum"},   frame_checksum_o, 32'd0);
        check({tag, "_count"},  32'(frame_count_o), 32'd0);
        check({tag, "_poserr"}, 32'(pos_err_o), 32'd0);
        check({tag, "_lineerr"}, 32'(line_err_o), 32'd0);
        check({tag, "_frameerr"}, 32'(frame_err_o), 32'd0);
    endtask

    initial begin
        reset_i = 1'b1; display_enable_i = 1'b0; hpos_i = '0; vpos_i = '0;
        red_i = '0; green_i = '0; blue_i = '0; err_clear_i = 1'b0;
        step(); step();
        reset_i = 1'b0;
        check_zero("reset");

        // Mid-frame start is ignored until (0,0)
        px(2, 1, 8'h00, 8'h00, 8'h01);
        px(3, 1, 8'h00, 8'h00, 8'h01);
        bl(1);
        check("midstart_synced", 32'(synced_o), 32'd0);
        check("midstart_poserr", 32'(pos_err_o), 32'd0);
        check("midstart_lineerr", 32'(line_err_o), 32'd0);
        px(0, 0, 8'h00, 8'h00, 8'h01);
        check("sync_after_origin", 32'(synced_o), 32'd1);

        // Clean frame
        for (int i = 1; i < H; i++) px(i, 0, 8'h00, 8'h00, 8'h01);
        bl(2); send_line(1, H); bl(2); send_line(2, H);
        check("t1_done_early", 32'(frame_done_o), 32'd0);
        bl(1);
        check("t1_done", 32'(frame_done_o), 32'd1);
        check("t1_csum", frame_checksum_o, 32'h00000FFF);
        check("t1_count", 32'(frame_count_o), 32'd1);
        check("t1_poserr", 32'(pos_err_o), 32'd0);
        check("t1_lineerr", 32'(line_err_o), 32'd0);
        check("t1_frameerr", 32'(frame_err_o), 32'd0);
        bl(1);
        check("t1_done_pulse", 32'(frame_done_o), 32'd0);
        check("t1_synced_hold", 32'(synced_o), 32'd1);

        // Overlong line 1, then clear
        send_line(0, H); bl(2); send_line(1, H + 1); bl(1);
        check("t2_lineerr", 32'(line_err_o), 32'd1);
        err_clear_i = 1'b1; bl(1); err_clear_i = 1'b0;
        check("t2_cleared", 32'(line_err_o), 32'd0);
        bl(1); send_line(2, H); bl(1);
        check("t2_done", 32'(frame_done_o), 32'd1);
        check("t2_csum", frame_checksum_o, 32'h00001FFF);
        check("t2_count", 32'(frame_count_o), 32'd2);
        check("t2_lineerr_after", 32'(line_err_o), 32'd0);
        bl(2);

        // Position error on line 2 pixel 2, with non-blue colours
        send_line(0, H); bl(2); send_line(1, H); bl(2);
        px(0, 2, 8'h00, 8'h00, 8'h01);
        px(1, 2, 8'h00, 8'h00, 8'h01);
        check("t3_poserr_pre", 32'(pos_err_o), 32'd0);
        px(3, 2, 8'h80, 8'h00, 8'h00);
        check("t3_poserr", 32'(pos_err_o), 32'd1);
        px(3, 2, 8'h00, 8'h01, 8'h00);
        bl(1);
        check("t3_done", 32'(frame_done_o), 32'd1);
        check("t3_csum", frame_checksum_o, 32'h01000EFC);
        check("t3_count", 32'(frame_count_o), 32'd3);
        bl(1);

        // Stray pixel in FRAME_WAIT coinciding with a clear keeps the flag
        err_clear_i = 1'b1;
        px(1, 0, 8'h00, 8'h00, 8'h01);
        check("clear_vs_set", 32'(pos_err_o), 32'd1);
        bl(1);
        err_clear_i = 1'b0;
        check("clear_pos", 32'(pos_err_o), 32'd0);
        check("fw_synced", 32'(synced_o), 32'd1);

        // Premature restart after two lines
        reset_i = 1'b1; step(); reset_i = 1'b0;
        check_zero("t4_reset");
        send_line(0, H); bl(2); send_line(1, H); bl(2);
        d0 = done_cnt;
        px(0, 0, 8'h00, 8'h00, 8'h01);
        check("t4_frameerr", 32'(frame_err_o), 32'd1);
        check("t4_no_done", 32'(frame_done_o), 32'd0);
        for (int i = 1; i < H; i++) px(i, 0, 8'h00, 8'h00, 8'h01);
        bl(2); send_line(1, H); bl(2); send_line(2, H); bl(1);
        check("t4_no_pulse", 32'(done_cnt - d0), 32'd0);
        check("t4_done", 32'(frame_done_o), 32'd1);
        check("t4_count", 32'(frame_count_o), 32'd1);
        check("t4_csum", frame_checksum_o, 32'h00000FFF);
        check("t4_frameerr_sticky", 32'(frame_err_o), 32'd1);
        bl(1);

        // Reset mid-line during frame 3
        send_line(0, H); bl(2); send_line(1, H); bl(2); send_line(2, H); bl(1);
        check("t6_count2", 32'(frame_count_o), 32'd2);
        bl(1);
        send_line(0, H); bl(2);
        px(0, 1, 8'h00, 8'h00, 8'h01);
        px(1, 1, 8'h00, 8'h00, 8'h01);
        reset_i = 1'b1; step(); reset_i = 1'b0;
        check_zero("t6_reset");
        px(2, 1, 8'h00, 8'h00, 8'h01);
        check("t6_nosync", 32'(synced_o), 32'd0);
        bl(1);
        send_line(0, H);
        check("t6_resync", 32'(synced_o), 32'd1);
        bl(2); send_line(1, H); bl(2); send_line(2, H); bl(1);
        check("t6_done", 32'(frame_done_o), 32'd1);
        check("t6_count", 32'(frame_count_o), 32'd1);
        check("t6_csum", frame_checksum_o, 32'h00000FFF);
        bl(2);
        check("total_pulses", 32'(done_cnt), 32'd6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
